// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1-to-4 demultiplexer.
// Channel encodings and the select-to-one-hot decode helper.
package demux_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] sel_t;

  localparam sel_t CH0 = 2'd0;
  localparam sel_t CH1 = 2'd1;
  localparam sel_t CH2 = 2'd2;
  localparam sel_t CH3 = 2'd3;

  function automatic logic [NUM_CH-1:0] sel_onehot(
    input sel_t s
  );
    logic [NUM_CH-1:0] oh;
    oh = '0;
    unique case (s)
      CH0: oh = 4'b0001;
      CH1: oh = 4'b0010;
      CH2: oh = 4'b0100;
      CH3: oh = 4'b1000;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: single-entry data register, valid bit,
// zero-gated data output, transfer counter and local ready.
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  input  logic             take,
  output logic [WIDTH-1:0] y,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             ready
);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  // A write wins over a drain so a full slot streams at one per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (we) begin
      data_q  <= d;
      valid_q <= 1'b1;
      cnt_q   <= cnt_q + CNT_W'(1);
    end else if (valid_q && take) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign y     = valid_q ? data_q : '0;
  assign valid = valid_q;
  assign cnt   = cnt_q;
  assign ready = !valid_q || take;

endmodule

// File: rtl/demux_1to4.sv
// Registered 1-to-4 demux: steers one valid/ready input stream
// into one of four single-entry output channels selected by s.
module demux_1to4
  import demux_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  sel_t             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] xfer_cnt0,
  output logic [CNT_W-1:0] xfer_cnt1,
  output logic [CNT_W-1:0] xfer_cnt2,
  output logic [CNT_W-1:0] xfer_cnt3
);

  logic [NUM_CH-1:0] sel_oh;
  logic [NUM_CH-1:0] we;
  logic [NUM_CH-1:0] slot_rdy;
  logic [NUM_CH-1:0] slot_vld;
  logic [WIDTH-1:0]  slot_y   [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt [NUM_CH];
  logic              accept;

  assign sel_oh   = sel_onehot(s);
  assign in_ready = !rst && slot_rdy[s];
  assign accept   = in_valid && in_ready;
  assign we       = accept ? sel_oh : '0;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .we    (we[k]),
      .d     (i),
      .take  (out_ready[k]),
      .y     (slot_y[k]),
      .valid (slot_vld[k]),
      .cnt   (slot_cnt[k]),
      .ready (slot_rdy[k])
    );
  end

  assign out_valid = slot_vld;
  assign y0        = slot_y[0];
  assign y1        = slot_y[1];
  assign y2        = slot_y[2];
  assign y3        = slot_y[3];
  assign xfer_cnt0 = slot_cnt[0];
  assign xfer_cnt1 = slot_cnt[1];
  assign xfer_cnt2 = slot_cnt[2];
  assign xfer_cnt3 = slot_cnt[3];

endmodule

// File: tb/tb_demux_1to4.sv
// Table-driven bench for demux_1to4 with a reference model whose
// post-edge expectations are queued and popped after each edge.
module tb_demux_1to4;
  import demux_pkg::*;

  localparam int W = 8;
  localparam int C = 2;
  localparam int NV = 30;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] i;
  sel_t         s;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [C-1:0] xfer_cnt0, xfer_cnt1, xfer_cnt2, xfer_cnt3;

  always #5 clk = ~clk;

  demux_1to4 #(
    .WIDTH (W),
    .CNT_W (C)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i         (i),
    .s         (s),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xfer_cnt0 (xfer_cnt0),
    .xfer_cnt1 (xfer_cnt1),
    .xfer_cnt2 (xfer_cnt2),
    .xfer_cnt3 (xfer_cnt3)
  );

  typedef struct {
    logic         rst;
    logic         vld;
    logic [1:0]   s;
    logic [W-1:0] d;
    logic [3:0]   ordy;
    logic         exp_rdy;
    logic [3:0]   exp_ov;
  } vec_t;

  typedef struct {
    logic [3:0]   ov;
    logic [W-1:0] y [4];
    logic [C-1:0] cnt [4];
  } exp_t;

  vec_t v [NV];
  exp_t sb [$];

  int errors = 0;
  int checks = 0;

  logic         m_vld [4];
  logic [W-1:0] m_dat [4];
  logic [C-1:0] m_cnt [4];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic setv(input int n, input logic r, input logic vl,
                      input logic [1:0] ss, input logic [W-1:0] dd,
                      input logic [3:0] orr, input logic er,
                      input logic [3:0] eo);
    v[n].rst = r;
    v[n].vld = vl;
    v[n].s = ss;
    v[n].d = dd;
    v[n].ordy = orr;
    v[n].exp_rdy = er;
    v[n].exp_ov = eo;
  endtask

  task automatic model_step(input vec_t t);
    logic acc;
    exp_t e;
    acc = t.vld && (!m_vld[t.s] || t.ordy[t.s]);
    for (int k = 0; k < 4; k++) begin
      if (t.rst) begin
        m_vld[k] = 1'b0;
        m_dat[k] = '0;
        m_cnt[k] = '0;
      end else if (acc && t.s == 2'(k)) begin
        m_vld[k] = 1'b1;
        m_dat[k] = t.d;
        m_cnt[k] = m_cnt[k] + 1'b1;
      end else if (m_vld[k] && t.ordy[k]) begin
        m_vld[k] = 1'b0;
      end
      e.ov[k] = m_vld[k];
      e.y[k] = m_vld[k] ? m_dat[k] : '0;
      e.cnt[k] = m_cnt[k];
    end
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      m_vld[k] = 1'b0;
      m_dat[k] = '0;
      m_cnt[k] = '0;
    end
    // rst vld s d ordy exp_rdy exp_ov
    setv(0,  1, 1, 0, 8'hFF, 4'b0000, 0, 4'b0000);
    setv(1,  1, 1, 2, 8'hFF, 4'b0000, 0, 4'b0000);
    setv(2,  0, 1, 0, 8'h01, 4'b1111, 1, 4'b0001);
    setv(3,  0, 1, 1, 8'h01, 4'b1111, 1, 4'b0010);
    setv(4,  0, 1, 2, 8'h00, 4'b1111, 1, 4'b0100);
    setv(5,  0, 1, 3, 8'h01, 4'b1111, 1, 4'b1000);
    setv(6,  0, 1, 0, 8'h00, 4'b1111, 1, 4'b0001);
    setv(7,  0, 1, 1, 8'h00, 4'b1111, 1, 4'b0010);
    setv(8,  0, 1, 2, 8'h01, 4'b1111, 1, 4'b0100);
    setv(9,  0, 1, 3, 8'h00, 4'b1111, 1, 4'b1000);
    setv(10, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000);
    setv(11, 0, 1, 1, 8'h01, 4'b0000, 1, 4'b0010);
    setv(12, 0, 0, 1, 8'h00, 4'b0000, 0, 4'b0010);
    setv(13, 0, 0, 2, 8'h00, 4'b0000, 1, 4'b0010);
    setv(14, 0, 1, 2, 8'h5A, 4'b0000, 1, 4'b0110);
    setv(15, 0, 0, 2, 8'h00, 4'b0000, 0, 4'b0110);
    setv(16, 0, 1, 3, 8'hA5, 4'b0000, 1, 4'b1110);
    setv(17, 0, 1, 3, 8'h3C, 4'b1000, 1, 4'b1110);
    setv(18, 0, 0, 0, 8'h00, 4'b1111, 1, 4'b0000);
    setv(19, 0, 1, 0, 8'h77, 4'b0000, 1, 4'b0001);
    setv(20, 0, 0, 0, 8'h00, 4'b0001, 1, 4'b0000);
    setv(21, 1, 1, 1, 8'h11, 4'b1111, 0, 4'b0000);
    setv(22, 0, 1, 1, 8'h21, 4'b0010, 1, 4'b0010);
    setv(23, 0, 1, 1, 8'h22, 4'b0010, 1, 4'b0010);
    setv(24, 0, 1, 1, 8'h23, 4'b0010, 1, 4'b0010);
    setv(25, 0, 1, 1, 8'h24, 4'b0010, 1, 4'b0010);
    setv(26, 0, 1, 1, 8'h25, 4'b0010, 1, 4'b0010);
    setv(27, 0, 0, 1, 8'h00, 4'b1111, 1, 4'b0000);
    setv(28, 0, 1, 2, 8'h09, 4'b0000, 1, 4'b0100);
    setv(29, 1, 0, 2, 8'h00, 4'b0000, 0, 4'b0000);

    for (int n = 0; n < NV; n++) begin
      @(negedge clk);
      rst = v[n].rst;
      in_valid = v[n].vld;
      s = v[n].s;
      i = v[n].d;
      out_ready = v[n].ordy;
      #1;
      chk($sformatf("in_ready[%0d]", n), 32'(in_ready),
          32'(v[n].exp_rdy));
      model_step(v[n]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk($sformatf("out_valid_tbl[%0d]", n), 32'(out_valid),
          32'(v[n].exp_ov));
      chk($sformatf("out_valid_mdl[%0d]", n), 32'(out_valid),
          32'(e.ov));
      chk($sformatf("y0[%0d]", n), 32'(y0), 32'(e.y[0]));
      chk($sformatf("y1[%0d]", n), 32'(y1), 32'(e.y[1]));
      chk($sformatf("y2[%0d]", n), 32'(y2), 32'(e.y[2]));
      chk($sformatf("y3[%0d]", n), 32'(y3), 32'(e.y[3]));
      chk($sformatf("cnt0[%0d]", n), 32'(xfer_cnt0), 32'(e.cnt[0]));
      chk($sformatf("cnt1[%0d]", n), 32'(xfer_cnt1), 32'(e.cnt[1]));
      chk($sformatf("cnt2[%0d]", n), 32'(xfer_cnt2), 32'(e.cnt[2]));
      chk($sformatf("cnt3[%0d]", n), 32'(xfer_cnt3), 32'(e.cnt[3]));
      // Hand-derived corner-case values on top of the model.
      if (n == 17) begin
        chk("sim_drain_y3", 32'(y3), 32'h3C);
        chk("sim_drain_vld3", 32'(out_valid[3]), 32'd1);
      end
      if (n == 14) begin
        chk("bp_y1", 32'(y1), 32'h01);
        chk("bp_y2", 32'(y2), 32'h5A);
      end
      if (n == 20) chk("drain_y0", 32'(y0), 32'h00);
      if (n == 26) begin
        chk("wrap_cnt1", 32'(xfer_cnt1), 32'd1);
        chk("wrap_cnt0", 32'(xfer_cnt0), 32'd0);
        chk("wrap_cnt3", 32'(xfer_cnt3), 32'd0);
      end
    end
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to4.md
# demux_1to4

Registered 1-to-4 demultiplexer with per-channel valid/ready handshake. One input stream with a 2-bit select is steered to exactly one of four output channels, each backed by a one-entry output register. Unselected and empty channels drive zero data, preserving classic demux output semantics. Sits between a single producer and four independent consumers in the datapath.

## Interface
- `WIDTH`, default 1: data width of the input and of each output channel.
- `CNT_W`, default 8: width of each per-channel transfer counter.
- `clk` input, 1 bit: clock; all state updates on its rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `i` input, WIDTH bits: input data.
- `s` input, 2 bits: channel select; 0 selects y0, 1 selects y1, 2 selects y2, 3 selects y3.
- `in_valid` input, 1 bit: producer presents `i`/`s`.
- `in_ready` output, 1 bit: the selected channel can accept this cycle.
- `y0`, `y1`, `y2`, `y3` outputs, WIDTH bits each: channel data, zero when the channel is empty.
- `out_valid` output, 4 bits: bit k means channel k holds data.
- `out_ready` input, 4 bits: bit k means consumer k takes the data this cycle.
- `xfer_cnt0` to `xfer_cnt3` outputs, CNT_W bits each: count of accepted inputs per channel.

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Load `i` into channel `s` and set `out_valid[s]`.
- `in_ready = !rst && (!out_valid[s] || out_ready[s])`. It is combinational on `s`, `out_valid` and `out_ready`. It depends only on the selected channel.
- Drain: when `out_valid[k] && out_ready[k]`, clear `out_valid[k]` and set `yk` to 0. The exception is a simultaneous accept into channel k (see below).
- Simultaneous drain and accept on the same channel:
  - The new data replaces the old.
  - `out_valid[k]` stays 1.
  - Full throughput is one transfer per cycle.
- Activity on other channels is independent. Several channels may drain in the same cycle as one accept.
- `yk` equals the stored data while `out_valid[k]`, else 0. Exactly one channel can change per accept, and non-selected channels are never written.
- `xfer_cnt[k]` increments by 1 on each accept into channel k. It wraps modulo 2^CNT_W.
- `in_valid=0`: no state change except drains. `i` and `s` are don't-care.
- `out_ready[k]` while `out_valid[k]=0` has no effect.

## Timing
- Latency: data accepted at edge N is visible on `yk` with `out_valid[k]=1` immediately after edge N, i.e. in cycle N+1.
- Reset: when `rst=1` at a rising edge, the following outputs are cleared:
  - all `out_valid` go to 0
  - all `y0`–`y3` go to 0
  - all `xfer_cnt` go to 0
- While `rst` is high, `in_ready=0` and no accept occurs.
- Reset mid-operation discards held data without requiring `out_ready`.
- No combinational path from `i` to any `yk`. The only combinational path to `in_ready` is from `s`, `out_ready` and `rst`.
- Counter wrap: 2^CNT_W−1 followed by one accept gives 0, with no flag.

## Structure
- Shared package `demux_pkg`:
  - constant `NUM_CH = 4`
  - `typedef logic [1:0] sel_t`
  - channel index encodings
- Sub-module `demux_slot`, instantiated 4 times. It contains:
  - the one-entry data register
  - the valid bit
  - the zero-gating of output data
  - the transfer counter
  - its local ready (`!valid || out_ready`)
- Top level decodes `s` into a one-hot write enable and muxes the slot ready signals onto `in_ready`.

## Test plan
- Reset: drive `rst=1` for 2 cycles with `in_valid=1`. Required: `in_ready=0`, `out_valid=0000`, all `y`=0, all counters 0.
- Select sweep, `WIDTH=1`, `out_ready=1111`: apply `i=0/1` for each `s=00,01,10,11`.
  - Only `y[s]` follows `i` one cycle later.
  - The other outputs stay 0.
  - `out_valid` is one-hot at bit s.
- Backpressure, `out_ready=0000`:
  - Accept `i=1`, `s=01`. Next cycle, `in_ready=0` for `s=01` and `in_ready=1` for `s=10`.
  - Accept into channel 2. Required: `out_valid=0110`, `y1=1`, `y2` holds its data.
- Simultaneous drain and accept, `WIDTH=8`:
  - Channel 3 holds 0xA5 with `out_ready[3]=1`. Accept 0x3C on `s=11` in the same cycle.
  - Required: `y3=0x3C`, `out_valid[3]` stays 1, `xfer_cnt3` increments by 1.
- Drain: channel 0 full, then `out_ready=0001` for one cycle with `in_valid=0`. Required: `out_valid[0]=0`, `y0=0` on the next cycle.
- Counter wrap, `CNT_W=2`: perform 5 accepts into channel 1. Required: `xfer_cnt1=1`, other counters 0.
